// File: rtl/tactile_pkg.sv
// Shared types and default sizing for the taxel frame buffer.
package tactile_pkg;

  localparam int unsigned DEF_SW_WIRE_CNT = 16;
  localparam int unsigned DEF_RD_WIRE_CNT = 16;
  localparam int unsigned DEF_DATA_WIDTH  = 12;
  localparam int unsigned DEF_CNT_WIDTH   = 8;
  localparam int unsigned DEF_TAXEL_CNT   = DEF_SW_WIRE_CNT * DEF_RD_WIRE_CNT;
  localparam int unsigned DEF_TAXEL_AW    = $clog2(DEF_TAXEL_CNT);

  typedef enum logic {SYNC, FILL}   fill_state_t;
  typedef enum logic {IDLE, STREAM} read_state_t;

endpackage

// File: rtl/frame_ram.sv
// Two-bank frame store: one write port, one registered read port; bank is the address MSB.
module frame_ram
  import tactile_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_TAXEL_AW + 1,
  parameter int unsigned DATA_W = DEF_DATA_WIDTH
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  // Registered read port
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem_q[rd_addr];
  end

endmodule

// File: rtl/taxel_frame_buffer.sv
// Assembles ADC samples into double-buffered taxel frames and streams good frames out.
module taxel_frame_buffer
  import tactile_pkg::*;
#(
  parameter int unsigned SW_WIRE_CNT = DEF_SW_WIRE_CNT,
  parameter int unsigned RD_WIRE_CNT = DEF_RD_WIRE_CNT,
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned CNT_WIDTH   = DEF_CNT_WIDTH
) (
  input  logic                                         clk_in,
  input  logic                                         rst_n,
  input  logic                                         valid_in,
  input  logic                                         error_in,
  input  logic [DATA_WIDTH-1:0]                        data_in,
  input  logic [$clog2(SW_WIRE_CNT):0]                 sw_sel,
  input  logic [$clog2(RD_WIRE_CNT):0]                 rd_sel,
  output logic                                         out_valid,
  input  logic                                         out_ready,
  output logic [DATA_WIDTH-1:0]                        out_data,
  output logic [$clog2(SW_WIRE_CNT*RD_WIRE_CNT)-1:0]   out_addr,
  output logic                                         out_last,
  output logic [15:0]                                  frame_cnt,
  output logic [CNT_WIDTH-1:0]                         drop_cnt,
  output logic                                         sync_lost
);

  localparam int unsigned N    = SW_WIRE_CNT * RD_WIRE_CNT;
  localparam int unsigned AW   = $clog2(N);
  localparam int unsigned IW   = AW + 1;
  localparam int unsigned SW_W = $clog2(SW_WIRE_CNT) + 1;
  localparam int unsigned RD_W = $clog2(RD_WIRE_CNT) + 1;

  fill_state_t           fill_q, fill_d;
  read_state_t           rd_q, rd_d;
  logic [AW-1:0]         exp_q, exp_d;
  logic                  bad_q, bad_d;
  logic                  wbank_q, wbank_d;
  logic [CNT_WIDTH-1:0]  drop_q, drop_d;
  logic                  sync_lost_q, sync_lost_d;
  logic [IW-1:0]         issue_q, issue_d;
  logic                  pipe_v_q, pipe_v_d;
  logic [AW-1:0]         pipe_addr_q, pipe_addr_d;
  logic                  skid_v_q, skid_v_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
  logic [AW-1:0]         skid_addr_q, skid_addr_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [AW-1:0]         out_addr_q, out_addr_d;
  logic                  out_last_q, out_last_d;
  logic [15:0]           frame_q, frame_d;

  logic [AW-1:0]         a_lo_c;
  logic                  in_range_c, a_zero_c, a_last_c;
  logic                  wr_en_c, start_c, drop_inc_c, xfer_c, issue_c;
  logic [1:0]            held_c;
  logic [DATA_WIDTH-1:0] ram_rd_data;

  // Taxel address of the incoming sample; only meaningful when in range
  always_comb begin
    in_range_c = (sw_sel < SW_W'(SW_WIRE_CNT)) && (rd_sel < RD_W'(RD_WIRE_CNT));
    a_lo_c     = AW'(sw_sel) * AW'(RD_WIRE_CNT) + AW'(rd_sel);
    a_zero_c   = in_range_c && (a_lo_c == '0);
    a_last_c   = (a_lo_c == AW'(N - 1));
  end

  frame_ram #(.ADDR_W(IW), .DATA_W(DATA_WIDTH)) u_ram (
    .clk     (clk_in),
    .wr_en   (wr_en_c),
    .wr_addr ({wbank_q, a_lo_c}),
    .wr_data (data_in),
    .rd_en   (issue_c),
    .rd_addr ({~wbank_q, issue_q[AW-1:0]}),
    .rd_data (ram_rd_data)
  );

  // Fill sequencing, bank swap decision, read issue and output/skid stage
  always_comb begin
    fill_d      = fill_q;
    exp_d       = exp_q;
    bad_d       = bad_q;
    wbank_d     = wbank_q;
    drop_d      = drop_q;
    sync_lost_d = 1'b0;
    rd_d        = rd_q;
    issue_d     = issue_q;
    pipe_addr_d = pipe_addr_q;
    skid_v_d    = skid_v_q;
    skid_data_d = skid_data_q;
    skid_addr_d = skid_addr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    out_last_d  = out_last_q;
    frame_d     = frame_q;
    wr_en_c     = 1'b0;
    start_c     = 1'b0;
    drop_inc_c  = 1'b0;

    if (fill_q == SYNC) begin
      if (valid_in && a_zero_c) begin
        wr_en_c = 1'b1;
        exp_d   = AW'(1);
        bad_d   = error_in;
        fill_d  = FILL;
      end
    end else if (valid_in) begin
      if (in_range_c && (a_lo_c == exp_q)) begin
        wr_en_c = 1'b1;
        exp_d   = exp_q + AW'(1);
        bad_d   = bad_q | error_in;
        if (a_last_c) begin
          fill_d = SYNC;
          if (bad_q || error_in) begin
            drop_inc_c = 1'b1;
          end else if (rd_q == IDLE) begin
            wbank_d = ~wbank_q;
            start_c = 1'b1;
          end else begin
            drop_inc_c = 1'b1;
          end
        end
      end else begin
        // Sequence break; a sample at address 0 restarts the frame at once
        sync_lost_d = 1'b1;
        drop_inc_c  = 1'b1;
        fill_d      = SYNC;
        if (a_zero_c) begin
          wr_en_c = 1'b1;
          exp_d   = AW'(1);
          bad_d   = error_in;
          fill_d  = FILL;
        end
      end
    end

    if (drop_inc_c && (drop_q != '1)) drop_d = drop_q + CNT_WIDTH'(1);

    // Issue a read only when out + skid can absorb everything in flight
    xfer_c  = out_valid_q && out_ready;
    held_c  = 2'(out_valid_q) + 2'(skid_v_q) + 2'(pipe_v_q) - 2'(xfer_c);
    issue_c = (rd_q == STREAM) && (issue_q != IW'(N)) && (held_c <= 2'd1);
    pipe_v_d = issue_c;
    if (issue_c) begin
      issue_d     = issue_q + IW'(1);
      pipe_addr_d = issue_q[AW-1:0];
    end
    if (start_c) begin
      rd_d    = STREAM;
      issue_d = '0;
    end

    if (!out_valid_q || xfer_c) begin
      if (skid_v_q) begin
        out_valid_d = 1'b1;
        out_data_d  = skid_data_q;
        out_addr_d  = skid_addr_q;
        out_last_d  = (skid_addr_q == AW'(N - 1));
        skid_v_d    = pipe_v_q;
        skid_data_d = ram_rd_data;
        skid_addr_d = pipe_addr_q;
      end else if (pipe_v_q) begin
        out_valid_d = 1'b1;
        out_data_d  = ram_rd_data;
        out_addr_d  = pipe_addr_q;
        out_last_d  = (pipe_addr_q == AW'(N - 1));
      end else begin
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end
    end else if (pipe_v_q) begin
      skid_v_d    = 1'b1;
      skid_data_d = ram_rd_data;
      skid_addr_d = pipe_addr_q;
    end

    if (xfer_c && out_last_q) begin
      rd_d    = IDLE;
      frame_d = frame_q + 16'd1;
    end
  end

  // State and output registers
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      fill_q      <= SYNC;
      rd_q        <= IDLE;
      exp_q       <= '0;
      bad_q       <= 1'b0;
      wbank_q     <= 1'b0;
      drop_q      <= '0;
      sync_lost_q <= 1'b0;
      issue_q     <= '0;
      pipe_v_q    <= 1'b0;
      pipe_addr_q <= '0;
      skid_v_q    <= 1'b0;
      skid_data_q <= '0;
      skid_addr_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_last_q  <= 1'b0;
      frame_q     <= '0;
    end else begin
      fill_q      <= fill_d;
      rd_q        <= rd_d;
      exp_q       <= exp_d;
      bad_q       <= bad_d;
      wbank_q     <= wbank_d;
      drop_q      <= drop_d;
      sync_lost_q <= sync_lost_d;
      issue_q     <= issue_d;
      pipe_v_q    <= pipe_v_d;
      pipe_addr_q <= pipe_addr_d;
      skid_v_q    <= skid_v_d;
      skid_data_q <= skid_data_d;
      skid_addr_q <= skid_addr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      out_last_q  <= out_last_d;
      frame_q     <= frame_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;
  assign out_last  = out_last_q;
  assign frame_cnt = frame_q;
  assign drop_cnt  = drop_q;
  assign sync_lost = sync_lost_q;

endmodule

// File: tb/tb_taxel_frame_buffer.sv
// Directed bench for taxel_frame_buffer (16x16 frame, 12-bit samples).
module tb_taxel_frame_buffer;

  logic        clk_in = 1'b0;
  logic        rst_n;
  logic        valid_in, error_in, out_ready;
  logic [11:0] data_in;
  logic [4:0]  sw_sel, rd_sel;
  logic        out_valid, out_last, sync_lost;
  logic [11:0] out_data;
  logic [7:0]  out_addr;
  logic [15:0] frame_cnt;
  logic [7:0]  drop_cnt;

  int total = 0;
  int bad   = 0;
  int sl_seen = 0;

  // Results of the last drain
  int n_words, n_last, last_pos, stall_bad, data_bad;

  taxel_frame_buffer dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .error_in  (error_in),
    .data_in   (data_in),
    .sw_sel    (sw_sel),
    .rd_sel    (rd_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .out_last  (out_last),
    .frame_cnt (frame_cnt),
    .drop_cnt  (drop_cnt),
    .sync_lost (sync_lost)
  );

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) if (sync_lost === 1'b1) sl_seen++;

  task automatic send_sample(input int a, input logic err, input logic [11:0] d);
    @(negedge clk_in);
    valid_in = 1'b1;
    error_in = err;
    data_in  = d;
    sw_sel   = 5'(a / 16);
    rd_sel   = 5'(a % 16);
  endtask

  task automatic send_frame(input int err_at, input int base);
    for (int a = 0; a < 256; a++) send_sample(a, (a == err_at), 12'(a + base));
    @(negedge clk_in);
    valid_in = 1'b0;
    error_in = 1'b0;
  endtask

  // Consume the stream at pct% readiness; records order, stall stability and last position
  task automatic drain(input int pct, input int base);
    int tail;
    logic pend, r, hl;
    logic [11:0] hd;
    logic [7:0] ha;
    n_words = 0; n_last = 0; last_pos = -1; stall_bad = 0; data_bad = 0;
    tail = -1; pend = 1'b0; hd = '0; ha = '0; hl = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (pend && (out_valid !== 1'b1 || out_data !== hd || out_addr !== ha || out_last !== hl))
        stall_bad++;
      r = ($urandom_range(99) < pct);
      out_ready = r;
      if (out_valid === 1'b1 && r) begin
        if (out_addr !== 8'(n_words) || out_data !== 12'(n_words + base)) data_bad++;
        if (out_last === 1'b1) begin
          n_last++;
          last_pos = n_words;
          if (tail < 0) tail = 4;
        end
        n_words++;
      end
      pend = (out_valid === 1'b1) && !r;
      hd = out_data; ha = out_addr; hl = out_last;
      @(negedge clk_in);
      if (tail == 0) break;
      if (tail > 0) tail--;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %0b want 0", out_valid); end
    total++; if (out_data !== 12'd0) begin bad++; $display("FAIL reset_data got %0d want 0", out_data); end
    total++; if (out_addr !== 8'd0) begin bad++; $display("FAIL reset_addr got %0d want 0", out_addr); end
    total++; if (out_last !== 1'b0) begin bad++; $display("FAIL reset_last got %0b want 0", out_last); end
    total++; if (frame_cnt !== 16'd0) begin bad++; $display("FAIL reset_frame got %0d want 0", frame_cnt); end
    total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL reset_drop got %0d want 0", drop_cnt); end
    total++; if (sync_lost !== 1'b0) begin bad++; $display("FAIL reset_sync got %0b want 0", sync_lost); end
  endtask

  task automatic test_clean_frame();
    send_frame(-1, 0);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lat_e0 got %0b want 0", out_valid); end
    @(negedge clk_in);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lat_e1 got %0b want 0", out_valid); end
    @(negedge clk_in);
    total++; if (out_valid !== 1'b1 || out_addr !== 8'd0 || out_data !== 12'd0)
      begin bad++; $display("FAIL lat_e2 got v=%0b a=%0d d=%0d want 1/0/0", out_valid, out_addr, out_data); end
    drain(100, 0);
    total++; if (n_words != 256) begin bad++; $display("FAIL clean_words got %0d want 256", n_words); end
    total++; if (data_bad != 0) begin bad++; $display("FAIL clean_data got %0d bad words want 0", data_bad); end
    total++; if (n_last != 1 || last_pos != 255) begin bad++; $display("FAIL clean_last got n=%0d pos=%0d want 1/255", n_last, last_pos); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL clean_idle got %0b want 0", out_valid); end
    total++; if (frame_cnt !== 16'd1) begin bad++; $display("FAIL clean_frame got %0d want 1", frame_cnt); end
    total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL clean_drop got %0d want 0", drop_cnt); end
  endtask

  task automatic test_backpressure();
    send_frame(-1, 0);
    drain(50, 0);
    total++; if (n_words != 256) begin bad++; $display("FAIL bp_words got %0d want 256", n_words); end
    total++; if (data_bad != 0) begin bad++; $display("FAIL bp_data got %0d bad words want 0", data_bad); end
    total++; if (stall_bad != 0) begin bad++; $display("FAIL bp_stall got %0d unstable stalls want 0", stall_bad); end
    total++; if (n_last != 1 || last_pos != 255) begin bad++; $display("FAIL bp_last got n=%0d pos=%0d want 1/255", n_last, last_pos); end
    total++; if (frame_cnt !== 16'd2) begin bad++; $display("FAIL bp_frame got %0d want 2", frame_cnt); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    send_frame(-1, 0);
    send_frame(-1, 12'h100);
    total++; if (drop_cnt !== 8'd1) begin bad++; $display("FAIL b2b_drop got %0d want 1", drop_cnt); end
    total++; if (out_valid !== 1'b1 || out_addr !== 8'd0 || out_data !== 12'd0)
      begin bad++; $display("FAIL b2b_hold got v=%0b a=%0d d=%0d want 1/0/0", out_valid, out_addr, out_data); end
    drain(100, 0);
    total++; if (n_words != 256 || data_bad != 0) begin bad++; $display("FAIL b2b_data got n=%0d bad=%0d want 256/0", n_words, data_bad); end
    total++; if (frame_cnt !== 16'd3) begin bad++; $display("FAIL b2b_frame got %0d want 3", frame_cnt); end
  endtask

  task automatic test_error_frame();
    int seen;
    seen = 0;
    send_frame(37, 12'h080);
    for (int i = 0; i < 8; i++) begin
      if (out_valid === 1'b1) seen++;
      @(negedge clk_in);
    end
    total++; if (seen != 0) begin bad++; $display("FAIL err_nostream got %0d valid cycles want 0", seen); end
    total++; if (drop_cnt !== 8'd2) begin bad++; $display("FAIL err_drop got %0d want 2", drop_cnt); end
    send_frame(-1, 12'h200);
    drain(100, 12'h200);
    total++; if (n_words != 256 || data_bad != 0) begin bad++; $display("FAIL err_next got n=%0d bad=%0d want 256/0", n_words, data_bad); end
    total++; if (frame_cnt !== 16'd4) begin bad++; $display("FAIL err_frame got %0d want 4", frame_cnt); end
  endtask

  task automatic test_seq_skip();
    int sl0, seen;
    sl0 = sl_seen; seen = 0;
    for (int a = 0; a <= 10; a++) send_sample(a, 1'b0, 12'(a));
    send_sample(12, 1'b0, 12'd12);
    send_sample(13, 1'b0, 12'd13);
    send_sample(14, 1'b0, 12'd14);
    @(negedge clk_in);
    valid_in = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid === 1'b1) seen++;
      @(negedge clk_in);
    end
    total++; if (sl_seen - sl0 != 1) begin bad++; $display("FAIL skip_pulse got %0d pulses want 1", sl_seen - sl0); end
    total++; if (drop_cnt !== 8'd3) begin bad++; $display("FAIL skip_drop got %0d want 3", drop_cnt); end
    total++; if (seen != 0) begin bad++; $display("FAIL skip_nostream got %0d valid cycles want 0", seen); end
    send_frame(-1, 12'h300);
    drain(100, 12'h300);
    total++; if (n_words != 256 || data_bad != 0) begin bad++; $display("FAIL skip_next got n=%0d bad=%0d want 256/0", n_words, data_bad); end
    total++; if (frame_cnt !== 16'd5) begin bad++; $display("FAIL skip_frame got %0d want 5", frame_cnt); end
  endtask

  task automatic test_reset_mid_stream();
    logic found;
    found = 1'b0;
    send_frame(-1, 12'h055);
    for (int i = 0; i < 600; i++) begin
      out_ready = 1'b1;
      if (out_valid === 1'b1 && out_addr === 8'd100) begin found = 1'b1; break; end
      @(negedge clk_in);
    end
    total++; if (found !== 1'b1) begin bad++; $display("FAIL mid_reach got %0b want 1", found); end
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got %0b want 0", out_valid); end
    total++; if (frame_cnt !== 16'd0 || drop_cnt !== 8'd0)
      begin bad++; $display("FAIL mid_counters got f=%0d d=%0d want 0/0", frame_cnt, drop_cnt); end
    @(negedge clk_in);
    @(negedge clk_in);
    rst_n = 1'b1;
    out_ready = 1'b0;
    send_frame(-1, 0);
    drain(100, 0);
    total++; if (n_words != 256 || data_bad != 0) begin bad++; $display("FAIL mid_next got n=%0d bad=%0d want 256/0", n_words, data_bad); end
    total++; if (frame_cnt !== 16'd1 || drop_cnt !== 8'd0)
      begin bad++; $display("FAIL mid_after got f=%0d d=%0d want 1/0", frame_cnt, drop_cnt); end
  endtask

  initial begin
    rst_n = 1'b0; valid_in = 1'b0; error_in = 1'b0; out_ready = 1'b0;
    data_in = '0; sw_sel = '0; rd_sel = '0;
    repeat (3) @(negedge clk_in);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk_in);
    test_clean_frame();
    test_backpressure();
    test_back_to_back();
    test_error_frame();
    test_seq_skip();
    test_reset_mid_stream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/taxel_frame_buffer.md
Name: taxel_frame_buffer

Overview:
Downstream of adc_read. Collects the 12-bit conversions it produces into a full SW_WIRE_CNT x RD_WIRE_CNT taxel frame, indexed by the mux_select wire selects. It double-buffers frames in two RAM banks. Completed good frames stream out in raster order over a valid/ready interface to the host link.

Parameters:
SW_WIRE_CNT, 16, number of switched (row) wires
RD_WIRE_CNT, 16, number of read (column) wires
DATA_WIDTH, 12, ADC sample width
CNT_WIDTH, 8, width of saturating drop counter

Ports:
clk_in  input  1  ADC-domain clock (same clock as adc_read/mux_select)
rst_n  input  1  asynchronous, active-low reset
valid_in  input  1  one-cycle strobe from adc_read valid_out
error_in  input  1  adc_read error_out, sampled with valid_in
data_in  input  DATA_WIDTH  adc_read read_out
sw_sel  input  $clog2(SW_WIRE_CNT)+1  current sw_mux_sel
rd_sel  input  $clog2(RD_WIRE_CNT)+1  current rd_mux_sel
out_valid  output  1  stream word valid
out_ready  input  1  consumer accept
out_data  output  DATA_WIDTH  taxel value
out_addr  output  $clog2(SW_WIRE_CNT*RD_WIRE_CNT)  taxel index of out_data
out_last  output  1  high with final taxel of a frame
frame_cnt  output  16  frames fully streamed, wraps
drop_cnt  output  CNT_WIDTH  frames discarded, saturates at all-ones
sync_lost  output  1  one-cycle pulse on sequence error

Behaviour:
- Reset (async assert, sync release): all outputs 0; fill FSM = SYNC; read FSM = IDLE; write bank = 0.
- Address: A = sw_sel*RD_WIRE_CNT + rd_sel, with N = SW*RD. sw_sel >= SW or rd_sel >= RD counts as a sequence error.
- Fill FSM (states SYNC, FILL):
  - SYNC: ignore valid_in unless A == 0. On A == 0, write the sample, set exp = 1, clear the bad flag, go to FILL.
  - FILL: on valid_in with A == exp, write the sample to the write bank and increment exp. If error_in is set, set bad (the sample is still written).
  - FILL: on valid_in with A != exp (or out of range), pulse sync_lost, increment drop_cnt, go to SYNC. If that same sample has A == 0, it restarts the frame immediately (treated as a SYNC hit).
  - Write of A == N-1:
    - If bad: drop_cnt++.
    - Else if read FSM is IDLE: swap banks and start streaming the completed bank.
    - Else (read busy): drop_cnt++ and keep the current write bank.
    - In all cases go to SYNC.
  - The completion decision uses the read FSM state registered before that edge. A stream finishing on the same cycle counts as busy.
- Read FSM (states IDLE, STREAM):
  - RAM read latency is 1 cycle, with a registered output stage plus a one-entry skid.
  - out_valid first rises 2 cycles after the swap edge.
  - Words are emitted at out_addr 0..N-1 in order, with out_last high on N-1.
  - A transfer occurs when out_valid && out_ready. While out_valid && !out_ready, out_data, out_addr and out_last hold stable.
  - Sustained throughput is 1 word/cycle with out_ready held high.
  - After the out_last transfer: frame_cnt++, return to IDLE, out_valid deasserts the next cycle.
- The write bank and read bank always differ. The filling bank is never read.
- valid_in high for more than one consecutive cycle: each cycle is treated as a separate sample.
- Reset mid-operation: out_valid drops asynchronously, the partial frame is lost, both FSMs restart.

Decomposition:
- Package tactile_pkg:
  - fill_state_t {SYNC, FILL}
  - read_state_t {IDLE, STREAM}
  - localparams for taxel count and address width, derived from the wire counts
- One sub-module, frame_ram: simple dual-port RAM, one write port and one registered read port, depth 2*N, DATA_WIDTH wide. The bank bit is the address MSB, so it infers BRAM.

Test Plan:
1. Clean frame, data = A for A = 0..255, out_ready = 1:
   - 256 words out, out_data == out_addr == 0..255.
   - out_last only on 255.
   - frame_cnt = 1, drop_cnt = 0.
2. Same frame with out_ready random at 50%:
   - Words identical and in order.
   - Outputs stable during every stall, no duplicates.
   - Exactly one out_last.
3. Two back-to-back frames with out_ready = 0 throughout:
   - First frame is held, second is dropped, drop_cnt = 1.
   - Releasing out_ready streams only frame 1 data.
4. error_in = 1 on sample A = 37:
   - No output for that frame, drop_cnt = 1.
   - Next clean frame streams normally, frame_cnt = 1.
5. Sequence skip (A = 10 followed by A = 12):
   - sync_lost pulses once, drop_cnt = 1.
   - Samples are ignored until the next A = 0; the following full frame streams.
6. Assert rst_n low mid-stream at word 100:
   - out_valid = 0 immediately, counters = 0.
   - After release, a new clean frame streams from address 0.
